// File: rtl/sobel_frame_ctrl.sv
// -----------------------------------------------------------------------------
// sobel_frame_ctrl
//
// APB register bank and frame sequencer for the Sobel edge datapath. Software
// programs the threshold, frame geometry, pixel total and the four kernel
// words. It then writes START. The block counts the incoming pixel stream,
// tracks the column/row of each accepted pixel and raises the line-buffer
// write and 3x3 window-valid strobes. After the last pixel it waits for the
// datapath pipeline to drain, then pulses sobel_done.
//
// Optional feature macro: SOBEL_IRQ_EN
//   defined   : adds output irq and register 0x28 IRQ_MASK (bit0).
//   undefined : no irq port; 0x28 is an unmapped address.
//
// Parameters
//   DIM_W      width of WIDTH/HEIGHT and the col/row counters
//   CNT_W      width of TOTAL and the pixel counter
//   DRAIN_CYC  cycles spent draining after the last pixel (>= 1)
//
// Ports
//   clk, reset_n        clock, asynchronous active-low reset
//   PSEL .. PSLVERR     APB slave (zero wait states, PADDR[7:0] decoded)
//   valid_in            pixel strobe from the stream source
//   threshold           THRESH[7:0] to the datapath
//   kernel1..kernel4    kernel configuration words
//   lb_wr_en            line-buffer write (pixel accepted this cycle)
//   col, row            position of the pixel currently being accepted
//   win_valid           registered; accepted pixel completed a 3x3 window
//   busy                sequencer is not idle
//   sobel_done          one-cycle frame-end pulse
//   irq                 (SOBEL_IRQ_EN only) done_sticky & IRQ_MASK, level
//
// Register map
//   0x00 THRESH  0x04 WIDTH  0x08 HEIGHT  0x0C TOTAL
//   0x10..0x1C KERNEL1..4
//   0x20 CTRL    bit0 START (write-only, reads 0)
//   0x24 STATUS  [0] busy [1] done_sticky [2] overrun; any write clears [2:1]
//   0x28 IRQ_MASK (SOBEL_IRQ_EN only)
// -----------------------------------------------------------------------------
module sobel_frame_ctrl #(
    parameter int DIM_W     = 16,
    parameter int CNT_W     = 32,
    parameter int DRAIN_CYC = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             PSEL,
    input  logic             PENABLE,
    input  logic             PWRITE,
    input  logic [31:0]      PADDR,
    input  logic [31:0]      PWDATA,
    output logic [31:0]      PRDATA,
    output logic             PREADY,
    output logic             PSLVERR,
    input  logic             valid_in,
    output logic [7:0]       threshold,
    output logic [31:0]      kernel1,
    output logic [31:0]      kernel2,
    output logic [31:0]      kernel3,
    output logic [31:0]      kernel4,
    output logic             lb_wr_en,
    output logic [DIM_W-1:0] col,
    output logic [DIM_W-1:0] row,
    output logic             win_valid,
    output logic             busy,
    output logic             sobel_done
`ifdef SOBEL_IRQ_EN
    ,
    output logic             irq
`endif
);

    localparam int DRN_W = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t state_q, state_d;

    logic [7:0]       thresh_q;
    logic [DIM_W-1:0] width_q;
    logic [DIM_W-1:0] height_q;
    logic [CNT_W-1:0] total_q;
    logic [31:0]      kern_q [4];
    logic [CNT_W-1:0] pix_cnt;
    logic [DRN_W-1:0] drain_cnt;
    logic             done_sticky;
    logic             overrun;
    logic             irq_mask;

    logic [7:0] addr;
    logic       access;
    logic       mapped;
    logic       is_cfg;
    logic       is_ctrl;
    logic       is_status;
    logic       is_mask;
    logic       start_bad;
    logic       wr_err;
    logic       wr_ok;
    logic       start_go;
    logic       status_clr;
    logic       accept;
    logic       last_pix;

    logic unused_addr;
    assign unused_addr = ^PADDR[31:8];

    assign addr   = PADDR[7:0];
    assign access = PSEL & PENABLE;
    assign PREADY = 1'b1;

    // Address decode and error classification. Only exact byte addresses
    // are mapped. START is checked against the geometry as it is now,
    // because those registers are frozen once the frame is running.
    always_comb begin
        mapped    = 1'b0;
        is_cfg    = 1'b0;
        is_ctrl   = 1'b0;
        is_status = 1'b0;
        is_mask   = 1'b0;
        case (addr)
            8'h00, 8'h04, 8'h08, 8'h0C,
            8'h10, 8'h14, 8'h18, 8'h1C: begin
                mapped = 1'b1;
                is_cfg = 1'b1;
            end
            8'h20: begin
                mapped  = 1'b1;
                is_ctrl = 1'b1;
            end
            8'h24: begin
                mapped    = 1'b1;
                is_status = 1'b1;
            end
`ifdef SOBEL_IRQ_EN
            8'h28: begin
                mapped  = 1'b1;
                is_mask = 1'b1;
            end
`endif
            default: mapped = 1'b0;
        endcase
        start_bad = (width_q < DIM_W'(3)) | (height_q < DIM_W'(3)) | (total_q == '0);
        wr_err    = ~mapped
                  | (is_cfg & busy)
                  | (is_ctrl & PWDATA[0] & (busy | start_bad));
        wr_ok      = access & PWRITE & ~wr_err;
        start_go   = wr_ok & is_ctrl & PWDATA[0];
        status_clr = wr_ok & is_status;
        PSLVERR    = access & (PWRITE ? wr_err : ~mapped);
    end

    // Read mux. It is combinational from PADDR and is held at zero whenever
    // the slave is not selected.
    always_comb begin
        PRDATA = 32'h0;
        if (PSEL) begin
            case (addr)
                8'h00: PRDATA = 32'(thresh_q);
                8'h04: PRDATA = 32'(width_q);
                8'h08: PRDATA = 32'(height_q);
                8'h0C: PRDATA = 32'(total_q);
                8'h10: PRDATA = kern_q[0];
                8'h14: PRDATA = kern_q[1];
                8'h18: PRDATA = kern_q[2];
                8'h1C: PRDATA = kern_q[3];
                8'h24: PRDATA = {29'h0, overrun, done_sticky, busy};
`ifdef SOBEL_IRQ_EN
                8'h28: PRDATA = {31'h0, irq_mask};
`endif
                default: PRDATA = 32'h0;
            endcase
        end
    end

    // Configuration registers. The error logic has already blocked writes
    // made while busy, so these only change between frames.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            thresh_q  <= '0;
            width_q   <= '0;
            height_q  <= '0;
            total_q   <= '0;
            kern_q[0] <= '0;
            kern_q[1] <= '0;
            kern_q[2] <= '0;
            kern_q[3] <= '0;
            irq_mask  <= 1'b0;
        end else if (wr_ok) begin
            case (addr)
                8'h00: thresh_q  <= PWDATA[7:0];
                8'h04: width_q   <= PWDATA[DIM_W-1:0];
                8'h08: height_q  <= PWDATA[DIM_W-1:0];
                8'h0C: total_q   <= PWDATA[CNT_W-1:0];
                8'h10: kern_q[0] <= PWDATA;
                8'h14: kern_q[1] <= PWDATA;
                8'h18: kern_q[2] <= PWDATA;
                8'h1C: kern_q[3] <= PWDATA;
                default: begin
                    if (is_mask) irq_mask <= PWDATA[0];
                end
            endcase
        end
    end

    assign accept   = valid_in & (state_q == RUN);
    assign last_pix = (pix_cnt + CNT_W'(1)) == total_q;

    // Sequencer state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // Next-state logic. TOTAL alone ends the frame; HEIGHT only gates START.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_go) state_d = RUN;
            RUN:     if (accept && last_pix) state_d = DRAIN;
            DRAIN:   if (drain_cnt == DRN_W'(DRAIN_CYC - 1)) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Pixel position and count tracking. win_valid is computed from the
    // position of the accepted pixel before it advances, so it lands one
    // cycle after acceptance.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            col       <= '0;
            row       <= '0;
            pix_cnt   <= '0;
            win_valid <= 1'b0;
            drain_cnt <= '0;
        end else begin
            win_valid <= accept & (row >= DIM_W'(2)) & (col >= DIM_W'(2));
            if (start_go) begin
                col     <= '0;
                row     <= '0;
                pix_cnt <= '0;
            end else if (accept) begin
                pix_cnt <= pix_cnt + CNT_W'(1);
                if (col == width_q - DIM_W'(1)) begin
                    col <= '0;
                    row <= row + DIM_W'(1);
                end else begin
                    col <= col + DIM_W'(1);
                end
            end
            if (state_q == DRAIN) drain_cnt <= drain_cnt + DRN_W'(1);
            else                  drain_cnt <= '0;
        end
    end

    // Sticky status bits. A clear and a set in the same cycle resolve to
    // set, so an event landing on the clearing write is not lost.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            done_sticky <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            if (status_clr || start_go) done_sticky <= 1'b0;
            if (state_q == DONE)        done_sticky <= 1'b1;
            if (status_clr)             overrun     <= 1'b0;
            if (valid_in && state_q != RUN) overrun <= 1'b1;
        end
    end

    assign threshold  = thresh_q;
    assign kernel1    = kern_q[0];
    assign kernel2    = kern_q[1];
    assign kernel3    = kern_q[2];
    assign kernel4    = kern_q[3];
    assign lb_wr_en   = accept;
    assign busy       = (state_q != IDLE);
    assign sobel_done = (state_q == DONE);

`ifdef SOBEL_IRQ_EN
    assign irq = done_sticky & irq_mask;
`else
    logic unused_mask;
    assign unused_mask = irq_mask;
`endif

endmodule

// File: tb/tb_sobel_frame_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sobel_frame_ctrl
//
// Directed bench for sobel_frame_ctrl. Inputs change on the falling edge.
// Outputs are sampled 1 time unit later, well clear of the rising edge.
// -----------------------------------------------------------------------------
module tb_sobel_frame_ctrl;

    logic        clk;
    logic        reset_n;
    logic        PSEL, PENABLE, PWRITE;
    logic [31:0] PADDR, PWDATA, PRDATA;
    logic        PREADY, PSLVERR;
    logic        valid_in;
    logic [7:0]  threshold;
    logic [31:0] kernel1, kernel2, kernel3, kernel4;
    logic        lb_wr_en;
    logic [15:0] col, row;
    logic        win_valid, busy, sobel_done;
`ifdef SOBEL_IRQ_EN
    logic        irq;
`endif

    int checks = 0;
    int errors = 0;

    sobel_frame_ctrl #(.DIM_W(16), .CNT_W(32), .DRAIN_CYC(4)) dut (
        .clk(clk), .reset_n(reset_n),
        .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
        .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA),
        .PREADY(PREADY), .PSLVERR(PSLVERR),
        .valid_in(valid_in), .threshold(threshold),
        .kernel1(kernel1), .kernel2(kernel2), .kernel3(kernel3), .kernel4(kernel4),
        .lb_wr_en(lb_wr_en), .col(col), .row(row),
        .win_valid(win_valid), .busy(busy), .sobel_done(sobel_done)
`ifdef SOBEL_IRQ_EN
        , .irq(irq)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Two-phase APB write. Call at a falling edge; returns at a falling edge.
    task automatic apb_write(input logic [31:0] a, input logic [31:0] d, output logic err);
        PSEL = 1'b1; PWRITE = 1'b1; PADDR = a; PWDATA = d; PENABLE = 1'b0;
        @(negedge clk);
        PENABLE = 1'b1;
        #1 err = PSLVERR;
        @(negedge clk);
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    endtask

    task automatic apb_read(input logic [31:0] a, output logic [31:0] d, output logic err);
        PSEL = 1'b1; PWRITE = 1'b0; PADDR = a; PENABLE = 1'b0;
        @(negedge clk);
        PENABLE = 1'b1;
        #1 begin d = PRDATA; err = PSLVERR; end
        @(negedge clk);
        PSEL = 1'b0; PENABLE = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        logic e;
        #1;
        checks++;
        if ({lb_wr_en, win_valid, busy, sobel_done} !== 4'b0 || col !== 16'd0 || row !== 16'd0
            || threshold !== 8'd0 || kernel1 !== 32'd0 || PREADY !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset_outputs: got wr=%b wv=%b busy=%b done=%b col=%0d row=%0d thr=%0d k1=%h ready=%b, need zeros/ready=1",
                     lb_wr_en, win_valid, busy, sobel_done, col, row, threshold, kernel1, PREADY);
        end
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        apb_read(32'h24, d, e);
        checks++;
        if (d !== 32'h0 || e !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_status: got %h err=%b, need 0 err=0", d, e);
        end
        apb_read(32'h04, d, e);
        checks++;
        if (d !== 32'h0) begin
            errors++;
            $display("[TB] FAIL reset_width: got %h, need 0", d);
        end
    endtask

    task automatic test_config();
        logic [31:0] addrs [8];
        logic [31:0] vals  [8];
        logic [31:0] d;
        logic e;
        addrs = '{32'h00, 32'h04, 32'h08, 32'h0C, 32'h10, 32'h14, 32'h18, 32'h1C};
        vals  = '{32'd100, 32'd10, 32'd10, 32'd100,
                  32'hFFFE_0001, 32'h0102_0304, 32'hA5A5_5A5A, 32'h8000_0007};
        for (int i = 0; i < 8; i++) begin
            apb_write(addrs[i], vals[i], e);
            checks++;
            if (e !== 1'b0) begin
                errors++;
                $display("[TB] FAIL cfg_write_err addr=%h: got %b, need 0", addrs[i], e);
            end
        end
        for (int i = 0; i < 8; i++) begin
            apb_read(addrs[i], d, e);
            checks++;
            if (d !== vals[i] || e !== 1'b0) begin
                errors++;
                $display("[TB] FAIL cfg_readback addr=%h: got %h err=%b, need %h err=0", addrs[i], d, e, vals[i]);
            end
        end
        checks++;
        if (threshold !== 8'd100 || kernel3 !== 32'hA5A5_5A5A || kernel4 !== 32'h8000_0007) begin
            errors++;
            $display("[TB] FAIL cfg_outputs: got thr=%0d k3=%h k4=%h, need 100 a5a55a5a 80000007", threshold, kernel3, kernel4);
        end
        apb_read(32'h20, d, e);
        checks++;
        if (d !== 32'h0 || e !== 1'b0) begin
            errors++;
            $display("[TB] FAIL ctrl_reads_zero: got %h err=%b, need 0 err=0", d, e);
        end
    endtask

    task automatic test_frame();
        logic e;
        logic [31:0] d;
        int wv_cnt = 0;
        int done_cnt = 0;
        int done_at = -1;
        apb_write(32'h20, 32'h1, e);
        checks++;
        if (e !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL frame_start: got err=%b busy=%b, need 0 1", e, busy);
        end
        for (int c = 0; c < 112; c++) begin
            valid_in = (c < 100);
            #1;
            if (win_valid === 1'b1) wv_cnt++;
            if (sobel_done === 1'b1) begin
                done_cnt++;
                done_at = c;
            end
            @(negedge clk);
        end
        valid_in = 1'b0;
        checks++;
        if (wv_cnt != 64) begin
            errors++;
            $display("[TB] FAIL frame_win_valid: got %0d pulses, need 64", wv_cnt);
        end
        checks++;
        if (done_cnt != 1 || done_at != 104) begin
            errors++;
            $display("[TB] FAIL frame_done: got %0d pulses last at cycle %0d, need 1 at 104", done_cnt, done_at);
        end
        apb_read(32'h24, d, e);
        checks++;
        if (d !== 32'h2) begin
            errors++;
            $display("[TB] FAIL frame_status: got %h, need 2", d);
        end
    endtask

    task automatic test_busy_errors();
        logic e;
        logic [31:0] d;
        apb_write(32'h20, 32'h1, e);
        apb_write(32'h04, 32'd5, e);
        checks++;
        if (e !== 1'b1) begin
            errors++;
            $display("[TB] FAIL busy_cfg_write: got err=%b, need 1", e);
        end
        apb_read(32'h04, d, e);
        checks++;
        if (d !== 32'd10) begin
            errors++;
            $display("[TB] FAIL busy_width_kept: got %0d, need 10", d);
        end
        apb_write(32'h20, 32'h1, e);
        checks++;
        if (e !== 1'b1) begin
            errors++;
            $display("[TB] FAIL busy_start: got err=%b, need 1", e);
        end
        apb_read(32'h24, d, e);
        checks++;
        if (d !== 32'h1) begin
            errors++;
            $display("[TB] FAIL busy_status: got %h, need 1", d);
        end
    endtask

    task automatic test_abort();
        int done_cnt = 0;
        for (int c = 0; c < 3; c++) begin
            valid_in = 1'b1;
            @(negedge clk);
        end
        reset_n = 1'b0;
        #1;
        checks++;
        if ({lb_wr_en, win_valid, busy, sobel_done} !== 4'b0 || col !== 16'd0 || row !== 16'd0
            || threshold !== 8'd0 || kernel2 !== 32'd0) begin
            errors++;
            $display("[TB] FAIL abort_outputs: got wr=%b wv=%b busy=%b done=%b col=%0d row=%0d thr=%0d k2=%h, need zeros",
                     lb_wr_en, win_valid, busy, sobel_done, col, row, threshold, kernel2);
        end
        valid_in = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        for (int c = 0; c < 10; c++) begin
            #1 if (sobel_done === 1'b1 || busy === 1'b1) done_cnt++;
            @(negedge clk);
        end
        checks++;
        if (done_cnt != 0) begin
            errors++;
            $display("[TB] FAIL abort_no_done: got %0d busy/done cycles, need 0", done_cnt);
        end
    endtask

    task automatic test_start_errors();
        logic e;
        logic [31:0] d;
        apb_write(32'h04, 32'd2, e);
        apb_write(32'h08, 32'd4, e);
        apb_write(32'h0C, 32'd8, e);
        apb_write(32'h20, 32'h1, e);
        checks++;
        if (e !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL start_width2: got err=%b busy=%b, need 1 0", e, busy);
        end
        apb_write(32'h04, 32'd4, e);
        apb_write(32'h0C, 32'd0, e);
        apb_write(32'h20, 32'h1, e);
        checks++;
        if (e !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL start_total0: got err=%b busy=%b, need 1 0", e, busy);
        end
        valid_in = 1'b1;
        #1;
        checks++;
        if (lb_wr_en !== 1'b0) begin
            errors++;
            $display("[TB] FAIL idle_wr_en: got %b, need 0", lb_wr_en);
        end
        @(negedge clk);
        valid_in = 1'b0;
        apb_read(32'h24, d, e);
        checks++;
        if (d !== 32'h4) begin
            errors++;
            $display("[TB] FAIL overrun_set: got %h, need 4", d);
        end
        apb_write(32'h24, 32'hDEAD_BEEF, e);
        checks++;
        if (e !== 1'b0) begin
            errors++;
            $display("[TB] FAIL status_clear_err: got %b, need 0", e);
        end
        apb_read(32'h24, d, e);
        checks++;
        if (d !== 32'h0) begin
            errors++;
            $display("[TB] FAIL status_cleared: got %h, need 0", d);
        end
        apb_read(32'h30, d, e);
        checks++;
        if (e !== 1'b1 || d !== 32'h0) begin
            errors++;
            $display("[TB] FAIL unmapped_read: got %h err=%b, need 0 err=1", d, e);
        end
`ifndef SOBEL_IRQ_EN
        apb_write(32'h28, 32'h1, e);
        checks++;
        if (e !== 1'b1) begin
            errors++;
            $display("[TB] FAIL mask_unmapped: got err=%b, need 1", e);
        end
`endif
    endtask

    task automatic test_gapped();
        logic e;
        logic [31:0] d;
        int k = 0;
        int wv_cnt = 0;
        int done_cnt = 0;
        int done_at = -1;
        int pos_err = 0;
        apb_write(32'h0C, 32'd16, e);
`ifdef SOBEL_IRQ_EN
        apb_write(32'h28, 32'h1, e);
`endif
        apb_write(32'h20, 32'h1, e);
        checks++;
        if (e !== 1'b0) begin
            errors++;
            $display("[TB] FAIL gap_start: got err=%b, need 0", e);
        end
        for (int c = 0; c < 60; c++) begin
            valid_in = (c % 3 == 0) && (k < 16);
            #1;
            if (win_valid === 1'b1) wv_cnt++;
            if (sobel_done === 1'b1) begin
                done_cnt++;
                done_at = c;
            end
            if (valid_in) begin
                checks++;
                if (lb_wr_en !== 1'b1 || col !== 16'(k % 4) || row !== 16'(k / 4)) begin
                    errors++;
                    pos_err++;
                    $display("[TB] FAIL gap_pos pixel %0d: got wr=%b col=%0d row=%0d, need 1 %0d %0d",
                             k, lb_wr_en, col, row, k % 4, k / 4);
                end
                k++;
            end
            @(negedge clk);
        end
        valid_in = 1'b0;
        checks++;
        if (wv_cnt != 4) begin
            errors++;
            $display("[TB] FAIL gap_win_valid: got %0d, need 4", wv_cnt);
        end
        checks++;
        if (done_cnt != 1 || done_at != 50) begin
            errors++;
            $display("[TB] FAIL gap_done: got %0d pulses last at %0d, need 1 at 50", done_cnt, done_at);
        end
`ifdef SOBEL_IRQ_EN
        checks++;
        if (irq !== 1'b1) begin
            errors++;
            $display("[TB] FAIL irq_set: got %b, need 1", irq);
        end
        apb_write(32'h24, 32'h0, e);
        #1;
        checks++;
        if (irq !== 1'b0) begin
            errors++;
            $display("[TB] FAIL irq_clear: got %b, need 0", irq);
        end
`else
        apb_read(32'h24, d, e);
        checks++;
        if (d !== 32'h2) begin
            errors++;
            $display("[TB] FAIL gap_status: got %h, need 2", d);
        end
`endif
        if (pos_err != 0) $display("[TB] %0d position errors", pos_err);
    endtask

    initial begin
        reset_n  = 1'b0;
        PSEL     = 1'b0;
        PENABLE  = 1'b0;
        PWRITE   = 1'b0;
        PADDR    = 32'h0;
        PWDATA   = 32'h0;
        valid_in = 1'b0;
        @(negedge clk);
        test_reset();
        test_config();
        test_frame();
        test_busy_errors();
        test_abort();
        test_start_errors();
        test_gapped();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
